// File: rtl/cache_line_mover.sv
// cache_line_mover: byte-serial writeback/fill sequencer between the cache arrays and the SDRAM strobe port.
// Optional CLM_CRITICAL_FIRST_EN: fill reads start at the requested byte offset and wrap within the line.
module cache_line_mover #(
   parameter int LINE_BYTES = 4,
   parameter int MEM_RD_LAT = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_wb,
   input  logic                    req_fill,
   input  logic [15:0]             req_wb_addr,
   input  logic [15:0]             req_fill_addr,
   input  logic [8*LINE_BYTES-1:0] wb_data,
   output logic [8*LINE_BYTES-1:0] fill_data,
   output logic                    done,
   output logic [15:0]             mem_add,
   output logic [7:0]              mem_din,
   output logic                    mem_wr_rd,
   output logic                    mem_strb,
   input  logic [7:0]              mem_dout
);
   localparam int OW = $clog2(LINE_BYTES);
   localparam logic [OW-1:0] LAST = OW'(LINE_BYTES - 1);
   localparam logic [MEM_RD_LAT-1:0] PV_LAST = MEM_RD_LAT'(1) << (MEM_RD_LAT - 1);

   typedef enum logic [2:0] {IDLE, WB, FILL, DRAIN, DONE} state_t;

   state_t                  state;
   logic [OW-1:0]           idx;
   logic [OW-1:0]           nidx;
   logic [OW-1:0]           req_off;
   logic [OW-1:0]           fill_off;
   logic [15:OW]            wb_hi;
   logic [15:OW]            fill_hi;
   logic [8*LINE_BYTES-1:0] wb_buf;
   logic                    do_fill;
   logic [MEM_RD_LAT-1:0]   pv;
   logic [OW-1:0]           ps [MEM_RD_LAT];
   logic                    unused_ok;

   assign nidx = idx + OW'(1);
`ifdef CLM_CRITICAL_FIRST_EN
   assign req_off = req_fill_addr[OW-1:0];
`else
   assign req_off = '0;
`endif
   assign unused_ok = ^{req_wb_addr[OW-1:0], req_fill_addr[OW-1:0], wb_buf[7:0]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         idx       <= '0;
         fill_off  <= '0;
         wb_hi     <= '0;
         fill_hi   <= '0;
         wb_buf    <= '0;
         do_fill   <= 1'b0;
         req_ready <= 1'b1;
         done      <= 1'b0;
         mem_strb  <= 1'b0;
         mem_wr_rd <= 1'b0;
         mem_add   <= '0;
         mem_din   <= '0;
      end else begin
         done      <= 1'b0;
         mem_strb  <= 1'b0;
         mem_wr_rd <= 1'b0;
         mem_add   <= '0;
         mem_din   <= '0;
         case (state)
            IDLE: if (req_valid) begin
               wb_hi     <= req_wb_addr[15:OW];
               fill_hi   <= req_fill_addr[15:OW];
               fill_off  <= req_off;
               wb_buf    <= wb_data;
               do_fill   <= req_fill;
               req_ready <= 1'b0;
               idx       <= '0;
               if (req_wb) begin
                  state     <= WB;
                  mem_strb  <= 1'b1;
                  mem_wr_rd <= 1'b1;
                  mem_add   <= {req_wb_addr[15:OW], OW'(0)};
                  mem_din   <= wb_data[7:0];
               end else if (req_fill) begin
                  state    <= FILL;
                  mem_strb <= 1'b1;
                  mem_add  <= {req_fill_addr[15:OW], req_off};
               end else begin
                  state <= DONE;
                  done  <= 1'b1;
               end
            end
            WB: if (idx == LAST) begin
               idx <= '0;
               if (do_fill) begin
                  state    <= FILL;
                  mem_strb <= 1'b1;
                  mem_add  <= {fill_hi, fill_off};
               end else begin
                  state <= DONE;
                  done  <= 1'b1;
               end
            end else begin
               idx       <= nidx;
               mem_strb  <= 1'b1;
               mem_wr_rd <= 1'b1;
               mem_add   <= {wb_hi, nidx};
               mem_din   <= wb_buf[8*nidx +: 8];
            end
            FILL: if (idx == LAST) begin
               state <= DRAIN;
            end else begin
               idx      <= nidx;
               mem_strb <= 1'b1;
               mem_add  <= {fill_hi, OW'(fill_off + nidx)};
            end
            // Only the oldest read still in flight means this edge captures the final byte.
            DRAIN: if (pv == PV_LAST) begin
               state <= DONE;
               done  <= 1'b1;
            end
            DONE: begin
               state     <= IDLE;
               req_ready <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Read slots travel with their strobe so each byte lands exactly MEM_RD_LAT cycles later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pv        <= '0;
         fill_data <= '0;
         for (int k = 0; k < MEM_RD_LAT; k++) ps[k] <= '0;
      end else begin
         for (int k = MEM_RD_LAT - 1; k > 0; k--) begin
            pv[k] <= pv[k-1];
            ps[k] <= ps[k-1];
         end
         pv[0] <= mem_strb && !mem_wr_rd;
         ps[0] <= mem_add[OW-1:0];
         if (pv[MEM_RD_LAT-1]) fill_data[8*ps[MEM_RD_LAT-1] +: 8] <= mem_dout;
      end
   end
endmodule
